// File: rtl/branch_predict_buffer_pkg.sv
// ---------------------------------------------------------------------------
// branch_predict_buffer_pkg
//   Shared types and constants for the fetch-side branch target buffer.
//   bpb_entry_t  : one table entry {valid, tag, target, ctr}
//   bpb_update_t : one pending training update {valid, idx, tag, taken, target}
//   CTR_WEAK_NT  : counter value every entry resets to
//   CTR_WEAK_T   : counter value a freshly allocated entry starts at
// ---------------------------------------------------------------------------
package branch_predict_buffer_pkg;

    localparam int BPB_ENTRIES = 64;
    localparam int BPB_IDX_W   = $clog2(BPB_ENTRIES);
    localparam int BPB_TAG_W   = 16;

    localparam logic [1:0] CTR_WEAK_NT = 2'b01;
    localparam logic [1:0] CTR_WEAK_T  = 2'b10;

    typedef struct packed {
        logic                 valid;
        logic [BPB_TAG_W-1:0] tag;
        logic [63:0]          target;
        logic [1:0]           ctr;
    } bpb_entry_t;

    typedef struct packed {
        logic                 valid;
        logic [BPB_IDX_W-1:0] idx;
        logic [BPB_TAG_W-1:0] tag;
        logic                 taken;
        logic [63:0]          target;
    } bpb_update_t;

    // Saturating 2-bit counter steps.
    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

endpackage

// File: rtl/branch_predict_buffer_ctr_next.sv
// ---------------------------------------------------------------------------
// bpb_ctr_next
//   Pure combinational training rule. Given the current contents of the
//   entry an update targets, produce the entry value after the update.
//   The same output drives both the table write and the lookup forward path,
//   so a forwarded prediction can never disagree with what gets written.
//   Ports:
//     old_entry  in   entry currently stored at upd.idx
//     upd        in   pending update (no effect when upd.valid = 0)
//     new_entry  out  entry value after applying upd
// ---------------------------------------------------------------------------
module bpb_ctr_next
    import branch_predict_buffer_pkg::*;
(
    input  bpb_entry_t  old_entry,
    input  bpb_update_t upd,
    output bpb_entry_t  new_entry
);

    logic tag_hit;
    logic unused_idx;

    // The caller selects the entry by index; only the tag matters here.
    assign unused_idx = ^upd.idx;
    assign tag_hit    = old_entry.valid && (old_entry.tag == upd.tag);

    always_comb begin
        new_entry = old_entry;
        if (upd.valid) begin
            if (tag_hit) begin
                if (upd.taken) begin
                    new_entry.ctr    = ctr_inc(old_entry.ctr);
                    new_entry.target = upd.target;
                end else begin
                    new_entry.ctr    = ctr_dec(old_entry.ctr);
                end
            end else if (upd.taken) begin
                // Taken branch with no usable entry: evict and allocate.
                new_entry.valid  = 1'b1;
                new_entry.tag    = upd.tag;
                new_entry.target = upd.target;
                new_entry.ctr    = CTR_WEAK_T;
            end
            // Not-taken on a miss leaves the entry untouched.
        end
    end

endmodule

// File: rtl/branch_predict_buffer.sv
// ---------------------------------------------------------------------------
// branch_predict_buffer
//   Direct-mapped branch target buffer with 2-bit saturating counters.
//   Supplies a same-cycle prediction for the PC being fetched and is trained
//   by the resolved-branch commit coming back from decode.
//
//   Commit interface: there is no back-pressure. A commit is consumed on any
//   rising edge where commit_valid is high; commit_is_branch qualifies whether
//   it trains the table and counts in the perf counters.
//
//   Training is two-stage: the commit is captured into a pending register at
//   the first edge and written into the table at the second. While pending,
//   lookups to the same index see the post-update entry via forwarding.
//
//   Ports:
//     clk, resetn                   clock, async active-low reset
//     lookup_pc                     PC being fetched
//     predict_pcsrc, predict_taken  prediction for lookup_pc
//     commit_valid, commit_is_branch, commit_pc, commit_taken,
//     commit_target, bp_hit         resolved-branch commit from decode
//     perf_branches, perf_miss      committed-branch and mispredict counts
// ---------------------------------------------------------------------------
module branch_predict_buffer
    import branch_predict_buffer_pkg::*;
#(
    parameter int ENTRIES = BPB_ENTRIES,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = BPB_TAG_W
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [63:0] lookup_pc,
    output logic [63:0] predict_pcsrc,
    output logic        predict_taken,
    input  logic        commit_valid,
    input  logic        commit_is_branch,
    input  logic [63:0] commit_pc,
    input  logic        commit_taken,
    input  logic [63:0] commit_target,
    input  logic        bp_hit,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_miss
);

    // ---------------- table storage ----------------
    // valid/ctr are reset; tag/target are only meaningful once valid is set.
    logic [ENTRIES-1:0] tbl_valid;
    logic [1:0]         tbl_ctr    [ENTRIES];
    logic [TAG_W-1:0]   tbl_tag    [ENTRIES];
    logic [63:0]        tbl_target [ENTRIES];

    bpb_update_t pend;
    bpb_entry_t  pend_old;
    bpb_entry_t  pend_new;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    bpb_entry_t       lk_entry;
    logic             lk_hit;
    logic             lk_aligned;

    logic [IDX_W-1:0] cm_idx;
    logic [TAG_W-1:0] cm_tag;
    logic             cm_branch;
    logic             unused_pc_bits;

    assign lk_idx    = lookup_pc[IDX_W+1:2];
    assign lk_tag    = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign cm_idx    = commit_pc[IDX_W+1:2];
    assign cm_tag    = commit_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign cm_branch = commit_valid && commit_is_branch;

    assign unused_pc_bits = ^{commit_pc[63:IDX_W+TAG_W+2], commit_pc[1:0]};

    // ---------------- training rule ----------------
    always_comb begin
        pend_old        = '0;
        pend_old.valid  = tbl_valid[pend.idx];
        pend_old.tag    = tbl_tag[pend.idx];
        pend_old.target = tbl_target[pend.idx];
        pend_old.ctr    = tbl_ctr[pend.idx];
    end

    bpb_ctr_next u_ctr_next (
        .old_entry (pend_old),
        .upd       (pend),
        .new_entry (pend_new)
    );

    // ---------------- stage 1: capture commit ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend <= '0;
        end else begin
            pend.valid  <= cm_branch;
            pend.idx    <= cm_idx;
            pend.tag    <= cm_tag;
            pend.taken  <= commit_taken;
            pend.target <= commit_target;
        end
    end

    // ---------------- stage 2: write table ----------------
    // A commit captured on this same edge is written on the next one and will
    // read the entry written here, so back-to-back updates accumulate.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tbl_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_ctr[i] <= CTR_WEAK_NT;
            end
        end else if (pend.valid) begin
            tbl_valid[pend.idx] <= pend_new.valid;
            tbl_ctr[pend.idx]   <= pend_new.ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (pend.valid) begin
            tbl_tag[pend.idx]    <= pend_new.tag;
            tbl_target[pend.idx] <= pend_new.target;
        end
    end

    // ---------------- lookup with forwarding ----------------
    always_comb begin
        if (pend.valid && (pend.idx == lk_idx)) begin
            lk_entry = pend_new;
        end else begin
            lk_entry        = '0;
            lk_entry.valid  = tbl_valid[lk_idx];
            lk_entry.tag    = tbl_tag[lk_idx];
            lk_entry.target = tbl_target[lk_idx];
            lk_entry.ctr    = tbl_ctr[lk_idx];
        end
    end

    // A misaligned fetch is never predicted taken; decode raises the fault.
    assign lk_aligned    = (lookup_pc[1:0] == 2'b00);
    assign lk_hit        = lk_entry.valid && (lk_entry.tag == lk_tag);
    assign predict_taken = lk_aligned && lk_hit && lk_entry.ctr[1];
    assign predict_pcsrc = predict_taken ? lk_entry.target : lookup_pc + 64'd4;

    // ---------------- performance counters ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_branches <= '0;
            perf_miss     <= '0;
        end else if (cm_branch) begin
            perf_branches <= perf_branches + 32'd1;
            if (!bp_hit) begin
                perf_miss <= perf_miss + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_buffer.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_buffer
//   Directed stimulus with hand-computed expectations pushed into queues; a
//   monitor on the falling edge pops and compares whenever a check strobe is
//   raised for that cycle.
// ---------------------------------------------------------------------------
module tb_branch_predict_buffer;

    logic        clk;
    logic        resetn;
    logic [63:0] lookup_pc;
    logic [63:0] predict_pcsrc;
    logic        predict_taken;
    logic        commit_valid;
    logic        commit_is_branch;
    logic [63:0] commit_pc;
    logic        commit_taken;
    logic [63:0] commit_target;
    logic        bp_hit;
    logic [31:0] perf_branches;
    logic [31:0] perf_miss;

    branch_predict_buffer dut (
        .clk              (clk),
        .resetn           (resetn),
        .lookup_pc        (lookup_pc),
        .predict_pcsrc    (predict_pcsrc),
        .predict_taken    (predict_taken),
        .commit_valid     (commit_valid),
        .commit_is_branch (commit_is_branch),
        .commit_pc        (commit_pc),
        .commit_taken     (commit_taken),
        .commit_target    (commit_target),
        .bp_hit           (bp_hit),
        .perf_branches    (perf_branches),
        .perf_miss        (perf_miss)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [64:0] exp_q[$];    // {taken, pcsrc}
    logic [63:0] perf_q[$];   // {branches, miss}
    logic        lk_chk;
    logic        perf_chk;
    int          n_checks;
    int          n_fail;

    always @(negedge clk) begin
        if (lk_chk) begin
            logic [64:0] e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL lookup pc=%h: expected queue empty", lookup_pc);
            end else begin
                e = exp_q.pop_front();
                if ({predict_taken, predict_pcsrc} !== e) begin
                    n_fail++;
                    $display("FAIL lookup pc=%h: got taken=%0b pcsrc=%h, want taken=%0b pcsrc=%h",
                             lookup_pc, predict_taken, predict_pcsrc, e[64], e[63:0]);
                end
            end
        end
        if (perf_chk) begin
            logic [63:0] p;
            n_checks++;
            if (perf_q.size() == 0) begin
                n_fail++;
                $display("FAIL perf: expected queue empty");
            end else begin
                p = perf_q.pop_front();
                if ({perf_branches, perf_miss} !== p) begin
                    n_fail++;
                    $display("FAIL perf: got branches=%0d miss=%0d, want branches=%0d miss=%0d",
                             perf_branches, perf_miss, p[63:32], p[31:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        commit_valid     = 1'b0;
        commit_is_branch = 1'b0;
        commit_taken     = 1'b0;
        bp_hit           = 1'b1;
        lk_chk           = 1'b0;
        perf_chk         = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic commit(input logic [63:0] pc, input logic tk, input logic [63:0] tgt,
                          input logic hit, input logic br, input logic cv);
        step();
        commit_valid     = cv;
        commit_is_branch = br;
        commit_pc        = pc;
        commit_taken     = tk;
        commit_target    = tgt;
        bp_hit           = hit;
    endtask

    task automatic br_commit(input logic [63:0] pc, input logic tk, input logic [63:0] tgt);
        commit(pc, tk, tgt, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic lookup(input logic [63:0] pc, input logic tk, input logic [63:0] exp_pc);
        step();
        lookup_pc = pc;
        lk_chk    = 1'b1;
        exp_q.push_back({tk, exp_pc});
    endtask

    task automatic check_perf(input logic [31:0] b, input logic [31:0] m);
        step();
        perf_chk = 1'b1;
        perf_q.push_back({b, m});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks         = 0;
        n_fail           = 0;
        resetn           = 1'b0;
        lookup_pc        = 64'h0;
        commit_valid     = 1'b0;
        commit_is_branch = 1'b0;
        commit_pc        = 64'h0;
        commit_taken     = 1'b0;
        commit_target    = 64'h0;
        bp_hit           = 1'b1;
        lk_chk           = 1'b0;
        perf_chk         = 1'b0;
        idle(2);
        resetn = 1'b1;
        idle(1);

        // Reset state
        lookup(64'h8000_0000, 1'b0, 64'h8000_0004);
        check_perf(32'd0, 32'd0);

        // Allocate and predict (ctr -> 2)
        br_commit(64'h8000_0010, 1'b1, 64'h8000_0100);
        idle(1);
        lookup(64'h8000_0010, 1'b1, 64'h8000_0100);

        // Not-taken on an empty entry does not allocate
        br_commit(64'h8000_0030, 1'b0, 64'h8000_0200);
        idle(1);
        lookup(64'h8000_0030, 1'b0, 64'h8000_0034);

        // Saturation: 4 taken back-to-back (2->3), 1 not-taken -> 2 (taken)
        for (int i = 0; i < 4; i++) br_commit(64'h8000_0010, 1'b1, 64'h8000_0100);
        br_commit(64'h8000_0010, 1'b0, 64'h8000_0999);
        idle(1);
        lookup(64'h8000_0010, 1'b1, 64'h8000_0100);
        // Second not-taken -> 1
        br_commit(64'h8000_0010, 1'b0, 64'h8000_0999);
        idle(1);
        lookup(64'h8000_0010, 1'b0, 64'h8000_0014);
        // Taken -> 2 with new target
        br_commit(64'h8000_0010, 1'b1, 64'h8000_0180);
        idle(1);
        lookup(64'h8000_0010, 1'b1, 64'h8000_0180);
        // Floor: 3 not-taken (2->1->0->0), 1 taken -> 1 (not taken)
        for (int i = 0; i < 3; i++) br_commit(64'h8000_0010, 1'b0, 64'h8000_0999);
        br_commit(64'h8000_0010, 1'b1, 64'h8000_0180);
        idle(1);
        lookup(64'h8000_0010, 1'b0, 64'h8000_0014);

        // Forwarding: lookup one edge after the commit, before the table write
        br_commit(64'h8000_0020, 1'b1, 64'h8000_0300);
        lookup(64'h8000_0020, 1'b1, 64'h8000_0300);
        // Misaligned fetch hitting the same entry is never taken
        lookup(64'h8000_0022, 1'b0, 64'h8000_0026);

        // Aliasing: 0x10 back to ctr 2
        br_commit(64'h8000_0010, 1'b1, 64'h8000_0180);
        idle(1);
        lookup(64'h8000_0010, 1'b1, 64'h8000_0180);
        lookup(64'h8000_0110, 1'b0, 64'h8000_0114);
        br_commit(64'h8000_0110, 1'b1, 64'h8000_0400);
        idle(1);
        lookup(64'h8000_0110, 1'b1, 64'h8000_0400);
        lookup(64'h8000_0010, 1'b0, 64'h8000_0014);
        // Allocated at ctr 2: one not-taken drops it below the taken threshold
        br_commit(64'h8000_0110, 1'b0, 64'h8000_0999);
        idle(1);
        lookup(64'h8000_0110, 1'b0, 64'h8000_0114);
        check_perf(32'd17, 32'd0);

        // Mid-run reset with an update still pending
        br_commit(64'h8000_0040, 1'b1, 64'h8000_0700);
        step();
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
        lookup(64'h8000_0040, 1'b0, 64'h8000_0044);
        lookup(64'h8000_0020, 1'b0, 64'h8000_0024);
        lookup(64'h8000_0000, 1'b0, 64'h8000_0004);
        check_perf(32'd0, 32'd0);

        // Perf counters: 10 branches (misses on 3rd, 6th, 9th), 5 non-branch
        // commits, and one branch with commit_valid low that must not count.
        for (int i = 0; i < 10; i++) begin
            commit(64'h8000_0060, 1'b0, 64'h8000_0600, (i % 3 != 2), 1'b1, 1'b1);
            if (i % 2 == 0) commit(64'h8000_0050, 1'b1, 64'h8000_0500, 1'b0, 1'b0, 1'b1);
        end
        commit(64'h8000_0060, 1'b1, 64'h8000_0600, 1'b0, 1'b1, 1'b0);
        idle(1);
        lookup(64'h8000_0050, 1'b0, 64'h8000_0054);
        lookup(64'h8000_0060, 1'b0, 64'h8000_0064);
        check_perf(32'd10, 32'd3);

        idle(3);
        n_checks++;
        if (exp_q.size() != 0 || perf_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d lookup / %0d perf entries left, want 0 / 0",
                     exp_q.size(), perf_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
